// File: rtl/doc5503_wave_mem_server_if.sv
// Wave-read, host-write and memory-port signals of the DOC5503 wave-memory server.
// The server takes the slave view. The DOC, host and memory environment takes the master view.
interface doc5503_wave_mem_server_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  wave_rd_i;
  logic [ADDR_WIDTH-1:0] wave_address_i;
  logic                  wave_data_ready_o;
  logic [7:0]            wave_data_o;
  logic                  host_wr_i;
  logic [ADDR_WIDTH-1:0] host_addr_i;
  logic [7:0]            host_data_i;
  logic                  host_busy_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [7:0]            mem_wdata_o;
  logic                  mem_ack_i;
  logic                  mem_rvalid_i;
  logic [7:0]            mem_rdata_i;
  logic                  overrun_o;
  logic                  timeout_o;
  logic                  clear_flags_i;

  modport slave (
    input  wave_rd_i, wave_address_i, host_wr_i, host_addr_i, host_data_i,
           mem_ack_i, mem_rvalid_i, mem_rdata_i, clear_flags_i,
    output wave_data_ready_o, wave_data_o, host_busy_o, mem_req_o, mem_we_o,
           mem_addr_o, mem_wdata_o, overrun_o, timeout_o
  );

  modport master (
    output wave_rd_i, wave_address_i, host_wr_i, host_addr_i, host_data_i,
           mem_ack_i, mem_rvalid_i, mem_rdata_i, clear_flags_i,
    input  wave_data_ready_o, wave_data_o, host_busy_o, mem_req_o, mem_we_o,
           mem_addr_o, mem_wdata_o, overrun_o, timeout_o
  );
endinterface

// File: rtl/doc5503_wave_mem_server.sv
// Serves DOC5503 wave reads from sound RAM using a 1-entry read cache and a 1-entry host write buffer.
// Buffered write data is forwarded to reads of the same address.
module doc5503_wave_mem_server #(
  parameter int         ADDR_WIDTH     = 16,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] TIMEOUT_DATA   = 8'h80
) (
  input logic                      clk_i,
  input logic                      reset_n_i,
  doc5503_wave_mem_server_if.slave bus
);
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, RD_REQ, RD_WAIT, RESPOND, WR_REQ} state_t;
  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] rd_addr, wb_addr, c_addr;
  logic [7:0]            wb_data, c_data, wave_data, resp_nx;
  logic                  wb_valid, c_valid, overrun, timeout;
  logic [TW-1:0]         tmo_cnt;
  logic                  wb_hit, c_hit, rd_accept, wr_done, wb_load, tmo_hit, fill, resp_ld;

  assign wb_hit    = wb_valid && (wb_addr == rd_addr);
  assign c_hit     = c_valid && (c_addr == rd_addr);
  assign rd_accept = (state == IDLE) && bus.wave_rd_i;
  assign wr_done   = (state == WR_REQ) && bus.mem_ack_i;
  // A write that is acked in the same cycle frees the slot for a new host write.
  assign wb_load   = bus.host_wr_i && (!wb_valid || wr_done);
  assign tmo_hit   = (state == RD_WAIT) && !bus.mem_rvalid_i && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nx = state;
    resp_ld  = 1'b0;
    resp_nx  = wave_data;
    fill     = 1'b0;
    case (state)
      IDLE:    if (bus.wave_rd_i) state_nx = LOOKUP;
               else if (wb_valid) state_nx = WR_REQ;
      LOOKUP:  if (wb_hit) begin
                 state_nx = RESPOND; resp_ld = 1'b1; resp_nx = wb_data;
               end else if (c_hit) begin
                 state_nx = RESPOND; resp_ld = 1'b1; resp_nx = c_data;
               end else state_nx = RD_REQ;
      // Zero-latency memories may return data in the ack cycle.
      RD_REQ:  if (bus.mem_ack_i) begin
                 if (bus.mem_rvalid_i) begin
                   state_nx = RESPOND; resp_ld = 1'b1; resp_nx = bus.mem_rdata_i; fill = 1'b1;
                 end else state_nx = RD_WAIT;
               end
      RD_WAIT: if (bus.mem_rvalid_i) begin
                 state_nx = RESPOND; resp_ld = 1'b1; resp_nx = bus.mem_rdata_i; fill = 1'b1;
               end else if (tmo_hit) begin
                 state_nx = RESPOND; resp_ld = 1'b1; resp_nx = TIMEOUT_DATA;
               end
      RESPOND: state_nx = IDLE;
      WR_REQ:  if (bus.mem_ack_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      rd_addr   <= '0;
      wave_data <= '0;
      tmo_cnt   <= '0;
      c_valid   <= 1'b0;
      c_addr    <= '0;
      c_data    <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state <= state_nx;
      if (rd_accept) rd_addr <= bus.wave_address_i;
      if (resp_ld) wave_data <= resp_nx;
      if (state == RD_REQ) tmo_cnt <= '0;
      else if (state == RD_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      if (fill) begin
        c_valid <= 1'b1;
        c_addr  <= rd_addr;
        c_data  <= bus.mem_rdata_i;
      end else if (wr_done && c_valid && (c_addr == wb_addr)) begin
        c_data <= wb_data;
      end
      if (wb_load) begin
        wb_valid <= 1'b1;
        wb_addr  <= bus.host_addr_i;
        wb_data  <= bus.host_data_i;
      end else if (wr_done) begin
        wb_valid <= 1'b0;
      end
      if (bus.wave_rd_i && (state != IDLE)) overrun <= 1'b1;
      else if (bus.clear_flags_i) overrun <= 1'b0;
      if (tmo_hit) timeout <= 1'b1;
      else if (bus.clear_flags_i) timeout <= 1'b0;
    end
  end

  assign bus.wave_data_ready_o = (state == RESPOND);
  assign bus.wave_data_o       = wave_data;
  assign bus.host_busy_o       = wb_valid;
  assign bus.mem_req_o         = (state == RD_REQ) || (state == WR_REQ);
  assign bus.mem_we_o          = (state == WR_REQ);
  assign bus.mem_addr_o        = (state == WR_REQ) ? wb_addr : rd_addr;
  assign bus.mem_wdata_o       = wb_data;
  assign bus.overrun_o         = overrun;
  assign bus.timeout_o         = timeout;
endmodule

// File: tb/tb_doc5503_wave_mem_server.sv
// Directed bench for doc5503_wave_mem_server with a behavioural sound-RAM responder.
module tb_doc5503_wave_mem_server;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   strobes = 0, strobe_cyc = 0, req_cnt = 0;
  logic [7:0] strobe_data = '0;

  doc5503_wave_mem_server_if #(.ADDR_WIDTH(16)) bus ();

  doc5503_wave_mem_server #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(255), .TIMEOUT_DATA(8'h80)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  typedef struct packed {logic we; logic [15:0] addr; logic [7:0] data;} mop_t;
  mop_t       log_q[$];
  logic [7:0] mem_arr [logic [15:0]];
  bit         withhold = 0, late_pulse = 0, rd_pend = 0;
  int         lat = 3, lat_left = 0;
  logic [7:0] rd_q = '0;

  // Memory responder: acks at the first negedge that sees a request, and returns read data lat cycles later.
  initial begin
    bus.mem_ack_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack_i = 0; bus.mem_rvalid_i = 0;
      if (!rst_n) rd_pend = 0;
      else begin
        if (rd_pend) begin
          if (lat_left > 0) lat_left--;
          if (lat_left == 0) begin
            rd_pend = 0;
            if (!withhold) begin bus.mem_rvalid_i = 1; bus.mem_rdata_i = rd_q; end
          end
        end else if (bus.mem_req_o) begin
          bus.mem_ack_i = 1;
          log_q.push_back({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o});
          if (bus.mem_we_o) mem_arr[bus.mem_addr_o] = bus.mem_wdata_o;
          else begin
            rd_q = mem_arr.exists(bus.mem_addr_o) ? mem_arr[bus.mem_addr_o] : 8'h00;
            lat_left = lat;
            if (lat == 0) begin
              if (!withhold) begin bus.mem_rvalid_i = 1; bus.mem_rdata_i = rd_q; end
            end else rd_pend = 1;
          end
        end
        if (late_pulse) begin bus.mem_rvalid_i = 1; bus.mem_rdata_i = 8'hEE; late_pulse = 0; end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.wave_data_ready_o) begin strobes++; strobe_cyc = cyc; strobe_data = bus.wave_data_o; end
    if (bus.mem_req_o) req_cnt++;
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, output int t0);
    bus.wave_rd_i = 1; bus.wave_address_i = a; t0 = cyc;
    step();
    bus.wave_rd_i = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.host_wr_i = 1; bus.host_addr_i = a; bus.host_data_i = d;
    step();
    bus.host_wr_i = 0;
  endtask

  task automatic wait_strobe(input int n0, input int budget, output bit got);
    int k = 0;
    while (strobes == n0 && k < budget) begin step(); k++; end
    got = (strobes != n0);
  endtask

  task automatic wait_idle_wb(output bit got);
    int k = 0;
    while (bus.host_busy_o && k < 50) begin step(); k++; end
    got = !bus.host_busy_o;
  endtask

  task automatic test_reset();
    step(3);
    n_chk++; if (bus.wave_data_ready_o !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.wave_data_ready_o); else n_pass++;
    n_chk++; if (bus.wave_data_o !== 8'h00) $display("FAIL reset_data got %h want 00", bus.wave_data_o); else n_pass++;
    n_chk++; if (bus.host_busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.host_busy_o); else n_pass++;
    n_chk++; if (bus.mem_req_o !== 1'b0) $display("FAIL reset_req got %b want 0", bus.mem_req_o); else n_pass++;
    n_chk++; if ({bus.overrun_o, bus.timeout_o} !== 2'b00) $display("FAIL reset_flags got %b want 00", {bus.overrun_o, bus.timeout_o}); else n_pass++;
    rst_n = 1;
    step(2);
  endtask

  task automatic test_read_miss();
    int t0, s0, r0; bit got;
    lat = 3; s0 = strobes; r0 = log_q.size();
    rd(16'h1234, t0);
    wait_strobe(s0, 50, got);
    n_chk++; if (!got) $display("FAIL miss_strobe no strobe within 50 cycles"); else n_pass++;
    n_chk++; if (strobe_data !== 8'h5A) $display("FAIL miss_data got %h want 5a", strobe_data); else n_pass++;
    n_chk++; if (strobe_cyc - t0 != 6) $display("FAIL miss_latency got %0d want 6", strobe_cyc - t0); else n_pass++;
    n_chk++; if (log_q.size() != r0 + 1 || log_q[r0] !== {1'b0, 16'h1234, 8'h00})
      $display("FAIL miss_memop got %0d ops want 1 read of 1234", log_q.size() - r0); else n_pass++;
    step(5);
    n_chk++; if (strobes != s0 + 1) $display("FAIL miss_one_strobe got %0d want 1", strobes - s0); else n_pass++;
  endtask

  task automatic test_read_hit();
    int t0, s0, q0; bit got;
    s0 = strobes; q0 = req_cnt;
    rd(16'h1234, t0);
    wait_strobe(s0, 20, got);
    step(3);
    n_chk++; if (!got || strobe_data !== 8'h5A) $display("FAIL hit_data got %h want 5a", strobe_data); else n_pass++;
    n_chk++; if (strobe_cyc - t0 != 2) $display("FAIL hit_latency got %0d want 2", strobe_cyc - t0); else n_pass++;
    n_chk++; if (req_cnt != q0) $display("FAIL hit_no_req got %0d req cycles want 0", req_cnt - q0); else n_pass++;
  endtask

  task automatic test_forward();
    int t0, s0, r0, q0; bit got;
    s0 = strobes; r0 = log_q.size();
    wr(16'h1234, 8'h77);
    n_chk++; if (bus.host_busy_o !== 1'b1) $display("FAIL fwd_busy got %b want 1", bus.host_busy_o); else n_pass++;
    rd(16'h1234, t0);
    wait_strobe(s0, 20, got);
    n_chk++; if (!got || strobe_data !== 8'h77) $display("FAIL fwd_data got %h want 77", strobe_data); else n_pass++;
    n_chk++; if (log_q.size() != r0) $display("FAIL fwd_before_write got %0d ops want 0", log_q.size() - r0); else n_pass++;
    wait_idle_wb(got);
    n_chk++; if (!got || log_q.size() != r0 + 1 || log_q[r0] !== {1'b1, 16'h1234, 8'h77})
      $display("FAIL fwd_write busy %b ops %0d want one write 1234<=77", bus.host_busy_o, log_q.size() - r0); else n_pass++;
    step(2);
    s0 = strobes; q0 = req_cnt;
    rd(16'h1234, t0);
    wait_strobe(s0, 20, got);
    n_chk++; if (!got || strobe_data !== 8'h77 || req_cnt != q0)
      $display("FAIL fwd_cache_update got %h reqs %0d want 77 reqs 0", strobe_data, req_cnt - q0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t0, s0, r0; bit got;
    s0 = strobes; r0 = log_q.size();
    wr(16'h2000, 8'h33);
    rd(16'h0010, t0);
    wait_strobe(s0, 50, got);
    n_chk++; if (!got || strobe_data !== 8'hC3) $display("FAIL b2b_data got %h want c3", strobe_data); else n_pass++;
    wait_idle_wb(got);
    n_chk++; if (!got || log_q.size() != r0 + 2 || log_q[r0] !== {1'b0, 16'h0010, 8'h33} || log_q[r0+1] !== {1'b1, 16'h2000, 8'h33})
      $display("FAIL b2b_order got %0d ops want read 0010 then write 2000", log_q.size() - r0); else n_pass++;
    n_chk++; if (mem_arr[16'h2000] !== 8'h33) $display("FAIL b2b_mem got %h want 33", mem_arr[16'h2000]); else n_pass++;
    step(2);
  endtask

  task automatic test_timeout();
    int t0, s0, q0; bit got;
    withhold = 1; s0 = strobes;
    rd(16'h0500, t0);
    wait_strobe(s0, 400, got);
    n_chk++; if (!got || strobe_data !== 8'h80) $display("FAIL tmo_data got %h want 80", strobe_data); else n_pass++;
    n_chk++; if (strobe_cyc - t0 != 258) $display("FAIL tmo_latency got %0d want 258", strobe_cyc - t0); else n_pass++;
    n_chk++; if (bus.timeout_o !== 1'b1) $display("FAIL tmo_flag got %b want 1", bus.timeout_o); else n_pass++;
    late_pulse = 1; s0 = strobes;
    step(5);
    n_chk++; if (strobes != s0) $display("FAIL tmo_late_discard got %0d strobes want 0", strobes - s0); else n_pass++;
    bus.clear_flags_i = 1; step(); bus.clear_flags_i = 0;
    n_chk++; if (bus.timeout_o !== 1'b0) $display("FAIL tmo_clear got %b want 0", bus.timeout_o); else n_pass++;
    withhold = 0; s0 = strobes; q0 = req_cnt;
    rd(16'h0500, t0);
    wait_strobe(s0, 50, got);
    n_chk++; if (!got || strobe_data !== 8'h42 || req_cnt == q0)
      $display("FAIL tmo_no_fill got %h reqs %0d want 42 with a memory read", strobe_data, req_cnt - q0); else n_pass++;
    step(2);
  endtask

  task automatic test_overrun_reset();
    int t0, t1, s0;
    withhold = 1;
    rd(16'h0700, t0);
    step(4);
    n_chk++; if (bus.overrun_o !== 1'b0) $display("FAIL ovr_pre got %b want 0", bus.overrun_o); else n_pass++;
    rd(16'h0900, t1);
    n_chk++; if (bus.overrun_o !== 1'b1) $display("FAIL ovr_set got %b want 1", bus.overrun_o); else n_pass++;
    s0 = strobes;
    rst_n = 0; #1;
    n_chk++; if (bus.mem_req_o !== 1'b0) $display("FAIL rst_mid_req got %b want 0", bus.mem_req_o); else n_pass++;
    n_chk++; if ({bus.wave_data_ready_o, bus.wave_data_o, bus.host_busy_o, bus.overrun_o, bus.timeout_o} !== 12'h000)
      $display("FAIL rst_mid_outs got %h want 000", {bus.wave_data_ready_o, bus.wave_data_o, bus.host_busy_o, bus.overrun_o, bus.timeout_o}); else n_pass++;
    step(2);
    rst_n = 1; withhold = 0;
    step(10);
    n_chk++; if (strobes != s0) $display("FAIL rst_no_strobe got %0d strobes want 0", strobes - s0); else n_pass++;
  endtask

  initial begin
    bus.wave_rd_i = 0; bus.wave_address_i = '0; bus.host_wr_i = 0; bus.host_addr_i = '0;
    bus.host_data_i = '0; bus.clear_flags_i = 0;
    mem_arr[16'h1234] = 8'h5A;
    mem_arr[16'h0010] = 8'hC3;
    mem_arr[16'h0500] = 8'h42;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_forward();
    test_back_to_back();
    test_timeout();
    test_overrun_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
